// File: rtl/adder_pipe_flow_ctrl_if.sv
// Stream and pipeline-control bundle between the adder flow controller and its neighbours.
// master = the flow controller; slave = producer/consumer/pipeline side.
interface adder_pipe_flow_ctrl_if #(
    parameter int WORD_WIDTH = 4,
    parameter int LAYERS     = 3,
    parameter int CNT_WIDTH  = 8
);
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] input_vector;
    logic [LAYERS-1:0]     hold_signals;
    logic [WORD_WIDTH-1:0] pipe_sum;
    logic                  pipe_err;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_err;
    logic                  alarm;
    logic [CNT_WIDTH-1:0]  err_count;
    logic [CNT_WIDTH-1:0]  drop_count;

    modport master (
        input  in_data, in_valid, pipe_sum, pipe_err, out_ready,
        output in_ready, input_vector, hold_signals, out_data, out_valid,
        output out_err, alarm, err_count, drop_count
    );

    modport slave (
        output in_data, in_valid, pipe_sum, pipe_err, out_ready,
        input  in_ready, input_vector, hold_signals, out_data, out_valid,
        input  out_err, alarm, err_count, drop_count
    );
endinterface

// File: rtl/adder_pipe_flow_ctrl.sv
// Occupancy-tracking flow controller for the cascaded adder pipeline; result valid LAYERS cycles after accept.
// Backpressure ripples combinationally from out_ready to in_ready; pipe_err flushes, counts and latches alarm.
module adder_pipe_flow_ctrl #(
    parameter int WORD_WIDTH = 4,
    parameter int LAYERS     = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    adder_pipe_flow_ctrl_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [LAYERS-1:0]    occ_q;
    logic [LAYERS-1:0]    en;
    logic [LAYERS-1:0]    drain;
    logic [LAYERS-1:0]    occ_n;
    logic                 alarm_q;
    logic [CNT_WIDTH-1:0] err_cnt_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;
    logic [CNT_WIDTH-1:0] err_cnt_n;
    logic [CNT_WIDTH-1:0] drop_cnt_n;
    logic [CNT_WIDTH:0]   drop_sum;

    function automatic logic [CNT_WIDTH:0] count_ones(input logic [LAYERS-1:0] v);
        logic [CNT_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < LAYERS; i++) begin
            c = c + (CNT_WIDTH+1)'(v[i]);
        end
        return c;
    endfunction

    // Evaluated top layer first: a layer may load only if it is empty or its
    // token moves on this cycle. Nothing here may look at pipe_err.
    always_comb begin
        logic [LAYERS:0]   src_ext;
        logic [LAYERS:0]   en_ext;
        logic [LAYERS-1:0] drain_v;
        src_ext          = {occ_q, bus.in_valid};
        en_ext           = '0;
        en_ext[LAYERS]   = bus.out_ready;
        drain_v          = '0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            drain_v[k] = en_ext[k+1];
            en_ext[k]  = src_ext[k] & (~occ_q[k] | drain_v[k]);
        end
        en    = en_ext[LAYERS-1:0];
        drain = drain_v;
    end

    assign occ_n = en | (occ_q & ~drain);

    assign bus.input_vector = bus.in_data;
    assign bus.hold_signals = ~en;
    assign bus.in_ready     = ~occ_q[0] | drain[0];
    assign bus.out_valid    = occ_q[LAYERS-1];
    assign bus.out_data     = bus.pipe_sum;
    assign bus.out_err      = bus.pipe_err;
    assign bus.alarm        = alarm_q;
    assign bus.err_count    = err_cnt_q;
    assign bus.drop_count   = drop_cnt_q;

    // Flushed tokens are those that would have been resident after this edge.
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + count_ones(occ_n);
        drop_cnt_n = drop_sum[CNT_WIDTH] ? CNT_MAX : drop_sum[CNT_WIDTH-1:0];
        err_cnt_n  = (err_cnt_q == CNT_MAX) ? CNT_MAX : err_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            alarm_q    <= 1'b0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (bus.pipe_err) begin
            occ_q      <= '0;
            alarm_q    <= 1'b1;
            err_cnt_q  <= err_cnt_n;
            drop_cnt_q <= drop_cnt_n;
        end else begin
            occ_q      <= occ_n;
        end
    end

endmodule

// File: tb/tb_adder_pipe_flow_ctrl.sv
// Bench for adder_pipe_flow_ctrl with a behavioural adder pipeline (sum = 4*x for LAYERS=3, W=4).
module tb_adder_pipe_flow_ctrl;
    localparam int W = 4;
    localparam int L = 3;
    localparam int C = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_pipe_flow_ctrl_if #(.WORD_WIDTH(W), .LAYERS(L), .CNT_WIDTH(C)) bus();

    adder_pipe_flow_ctrl #(.WORD_WIDTH(W), .LAYERS(L), .CNT_WIDTH(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pipeline model: each layer carries the word and a running sum, frozen by its hold bit.
    logic [W-1:0] px [L];
    logic [W-1:0] pacc [L];
    always @(posedge clk) begin
        if (!bus.hold_signals[0]) begin
            px[0]   <= bus.input_vector;
            pacc[0] <= bus.input_vector + bus.input_vector;
        end
        if (!bus.hold_signals[1]) begin
            px[1]   <= px[0];
            pacc[1] <= pacc[0] + px[0];
        end
        if (!bus.hold_signals[2]) begin
            px[2]   <= px[1];
            pacc[2] <= pacc[1] + px[1];
        end
    end
    assign bus.pipe_sum = pacc[L-1];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   beats   = 0;
    int   exp_q[$];
    logic accepted;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // One cycle of stimulus; e is the hand-computed sum expected for d if it is accepted.
    task automatic step(input logic v, input logic [W-1:0] d, input int e,
                        input logic ordy, input logic perr);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.pipe_err  = perr;
        #1;
        accepted = v & bus.in_ready & ~rst;
        if (accepted && !perr) exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every clean output transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready && !bus.out_err) begin
                beats++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_beat: got data %0d with no beat outstanding", bus.out_data);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    n_tests--;
                    check("out_data", int'(bus.out_data), e);
                end
            end
        end
    end

    initial begin
        int b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.pipe_err  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_hold_idle", int'(bus.hold_signals), 7);
        check("rst_alarm", int'(bus.alarm), 0);
        check("rst_err_count", int'(bus.err_count), 0);
        check("rst_drop_count", int'(bus.drop_count), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd9;
        #1;
        check("rst_hold_valid", int'(bus.hold_signals), 6);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post_rst_out_valid", int'(bus.out_valid), 0);

        // Streaming 3,5,1,7 at full rate
        step(1'b1, 4'd3, 12, 1'b1, 1'b0);
        step(1'b1, 4'd5, 4, 1'b1, 1'b0);
        check("lat_c1", int'(bus.out_valid), 0);
        step(1'b1, 4'd1, 4, 1'b1, 1'b0);
        check("lat_c2", int'(bus.out_valid), 0);
        step(1'b1, 4'd7, 12, 1'b1, 1'b0);
        check("lat_c3", int'(bus.out_valid), 1);
        check("hold_full", int'(bus.hold_signals), 0);
        repeat (4) step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        check("stream_drained", exp_q.size(), 0);

        // Parking under backpressure
        step(1'b1, 4'd3, 12, 1'b0, 1'b0);
        repeat (2) step(1'b0, 4'd0, 0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 0, 1'b0, 1'b0);
        check("park_valid", int'(bus.out_valid), 1);
        check("park_data", int'(bus.out_data), 12);
        repeat (6) step(1'b0, 4'd0, 0, 1'b0, 1'b0);
        check("park_valid_late", int'(bus.out_valid), 1);
        check("park_data_late", int'(bus.out_data), 12);
        check("park_hold", int'(bus.hold_signals), 7);
        step(1'b1, 4'd6, 8, 1'b0, 1'b0);
        check("fill1_acc", int'(accepted), 1);
        step(1'b1, 4'd2, 8, 1'b0, 1'b0);
        check("fill2_acc", int'(accepted), 1);
        step(1'b1, 4'd9, 4, 1'b0, 1'b0);
        check("full_in_ready", int'(bus.in_ready), 0);
        check("full_hold", int'(bus.hold_signals), 7);
        step(1'b1, 4'd9, 4, 1'b1, 1'b0);
        check("release_acc", int'(accepted), 1);
        repeat (5) step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        check("park_drained", exp_q.size(), 0);

        // Idle gaps
        b0 = beats;
        step(1'b1, 4'd1, 4, 1'b1, 1'b0);
        step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        check("hold_bubble", int'(bus.hold_signals), 5);
        step(1'b1, 4'd2, 8, 1'b1, 1'b0);
        step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        step(1'b1, 4'd15, 12, 1'b1, 1'b0);
        repeat (4) step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        check("gap_beats", beats - b0, 3);
        check("gap_drained", exp_q.size(), 0);

        // Flush with full pipeline and no transfers
        step(1'b1, 4'd1, 4, 1'b0, 1'b0);
        step(1'b1, 4'd2, 8, 1'b0, 1'b0);
        step(1'b1, 4'd3, 12, 1'b0, 1'b0);
        step(1'b0, 4'd0, 0, 1'b0, 1'b1);
        check("flush_out_err", int'(bus.out_err), 1);
        exp_q.delete();
        step(1'b0, 4'd0, 0, 1'b0, 1'b0);
        check("flush_out_valid", int'(bus.out_valid), 0);
        check("flush_in_ready", int'(bus.in_ready), 1);
        check("flush_alarm", int'(bus.alarm), 1);
        check("flush_err_count", int'(bus.err_count), 1);
        check("flush_drop_count", int'(bus.drop_count), 3);
        step(1'b1, 4'd5, 4, 1'b1, 1'b0);
        repeat (4) step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        check("flush_alarm_sticky", int'(bus.alarm), 1);
        check("flush_drained", exp_q.size(), 0);

        // Error counter saturation
        repeat (200) step(1'b0, 4'd0, 0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 0, 1'b1, 1'b1);
        check("err_mid", int'(bus.err_count), 201);
        repeat (99) step(1'b0, 4'd0, 0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        check("err_sat", int'(bus.err_count), 255);
        check("drop_unchanged", int'(bus.drop_count), 3);

        // Reset mid-stream with occ=110
        step(1'b1, 4'd1, 4, 1'b0, 1'b0);
        step(1'b1, 4'd2, 8, 1'b0, 1'b0);
        step(1'b0, 4'd0, 0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 0, 1'b0, 1'b0);
        check("pre_rst_out_valid", int'(bus.out_valid), 1);
        check("pre_rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        check("mid_rst_alarm", int'(bus.alarm), 0);
        check("mid_rst_err_count", int'(bus.err_count), 0);
        check("mid_rst_drop_count", int'(bus.drop_count), 0);
        b0 = beats;
        step(1'b1, 4'd6, 8, 1'b1, 1'b0);
        repeat (4) step(1'b0, 4'd0, 0, 1'b1, 1'b0);
        check("post_rst_beats", beats - b0, 1);
        check("post_rst_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
